lif_array: RTL
==============

# lif_array

Parametrised array of `N` leaky integrate-and-fire neurons that update in parallel on each valid input beat. The array is the next-generation neuron core. Each channel adds the following to the single-neuron behaviour:
- configurable width;
- saturating integration;
- runtime-programmable threshold and leak;
- a refractory period;
- an aggregate spike-event counter.

It sits between the input-current source and the spike consumer, with a small register-write port for configuration.

## Interface
Parameters:
- `N`, 4: number of neuron channels.
- `W`, 8: membrane potential and current width in bits.
- `REF_W`, 3: refractory counter width in bits.
- `THRESH_RST`, 15: threshold value after reset.
- `LEAK_RST`, 1: leak shift after reset.
- `REF_RST`, 0: refractory period after reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `current` is valid this cycle; the neurons update only when this is high.
- `current`  in  `N*W`  per-channel input current; channel i occupies `[i*W +: W]`, unsigned.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_sel`  in  2  register select:
  - 0: threshold, uses `cfg_data[W-1:0]`.
  - 1: refractory period, uses `cfg_data[REF_W-1:0]`.
  - 2: leak shift, uses `cfg_data[2:0]`, clamped to W-1.
  - 3: clear `spike_count`; `cfg_data` is ignored.
- `cfg_data`  in  `W`  configuration write data.
- `state`  out  `N*W`  per-channel membrane potential.
- `spike`  out  `N`  per-channel spike, valid when `spike_valid` is high.
- `refractory`  out  `N`  per-channel flag, high while that channel's refractory counter is non-zero.
- `spike_valid`  out  1  `in_valid` delayed by one cycle.
- `spike_count`  out  16  running total of spikes across all channels, saturating.

## Operation
- **Reset:** while `reset` is high, outputs are forced immediately, without waiting for a clock edge.
  - `state`, `spike`, `refractory`, `spike_valid`, `spike_count` and all refractory counters go to 0.
  - Threshold goes to `THRESH_RST`, leak to `LEAK_RST`, refractory period to `REF_RST`.
  - Reset asserted mid-operation abandons every count in progress.
- **Cycle with `in_valid` high**, per channel i, computed from pre-edge values:
  - **Refractory channel** (counter non-zero):
    - counter decrements by 1;
    - `state` is held at 0;
    - `spike` = 0;
    - the channel's `current` is ignored.
  - **Active channel**:
    - `sum = current_i + (state_i >> leak)`, computed at W+1 bits;
    - `sum` saturates to 2^W−1 and must never wrap.
  - **If `sum` ≥ threshold:**
    - `spike` = 1;
    - `state` ← 0;
    - counter ← refractory period.
  - **Otherwise:** `spike` = 0 and `state` ← `sum`.
  - Threshold 0 means every non-refractory valid cycle spikes.
  - Leak 0 means no leak (pure integrator).
  - Refractory period 0 means no refractory cycles.
- **Cycle with `in_valid` low:**
  - `state` and refractory counters hold;
  - `spike` = 0;
  - `spike_valid` = 0.
  - Refractory time counts valid beats only, not clock cycles.
- **`spike_count`:**
  - increments by the number of channels spiking in the cycle;
  - saturates at 0xFFFF.
  - A clear (`cfg_sel` = 3) in the same cycle as spikes takes priority; the count goes to 0.
- **Configuration writes:**
  - a write lands on the clock edge;
  - a neuron update in the same cycle uses the old value, and the new value applies from the next cycle;
  - changing the refractory period does not alter counters already running.

## Timing
- Latency is one cycle: `current` sampled on edge k appears as `state`, `spike` and `spike_valid` after edge k.
- All outputs are registered, with no combinational path from inputs to outputs.
- Full throughput: `in_valid` may be held high indefinitely.
- There is no backpressure.
- `spike` is a single-cycle pulse for each valid beat that fires.

## Test plan
- **Basic integration:** reset with default parameters; ch0 `current` = 8 with `in_valid` held high.
  - Required: `state` goes 8, 12, 14, then 0 with `spike[0]` = 1 on the 4th beat.
  - Required: `spike_count` = 1.
  - Separately, `current` = 5 settles at `state` 9 with no spike.
- **Saturation:** leak ← 0, threshold ← 255; ch2 `current` = 200 for 2 beats.
  - Required: beat 1 `state` = 200; beat 2 `sum` saturates to 255 (not 144) and `spike[2]` = 1.
- **Refractory with gaps:** period ← 2; ch1 `current` = 20.
  - Required: spike on beat 1, then `refractory[1]` = 1 and `state` 0 for beats 2–3, then spike again on beat 4.
  - Inserting idle cycles with `in_valid` low between beats leaves the counter unchanged.
- **Configuration concurrency:** threshold 15, ch0 `state` 0; write threshold ← 10 in the same cycle as `current` = 12.
  - Required: `state` = 12 with no spike.
  - Next beat with `current` 12: 12 + 6 = 18 ≥ 10, so spike.
- **Idle hold:** `state` 9, `in_valid` low for 5 cycles.
  - Required: `state` stays 9; `spike` and `spike_valid` stay 0.
- **Counter and reset:**
  - All 4 channels spike each beat: `spike_count` increases by 4 per beat.
  - Clear in the same cycle as spikes: `spike_count` = 0.
  - Assert `reset` mid-refractory: all outputs go to 0 before the next edge, and the threshold returns to 15.

Source files
------------

// File: rtl/lif_array_if.sv
// ----------------------------------------------------------------------------
// lif_array_if
// Bus between the input-current source / configuration master and the
// lif_array neuron core.
//   in_valid    : current beat valid (no backpressure)
//   current     : N x W unsigned per-channel input currents, channel i at [i*W +: W]
//   cfg_we      : configuration write strobe
//   cfg_sel     : 0 threshold, 1 refractory period, 2 leak shift, 3 clear spike_count
//   cfg_data    : configuration write data
//   state       : N x W membrane potentials
//   spike       : per-channel spike pulse, qualified by spike_valid
//   refractory  : per-channel refractory flag
//   spike_valid : in_valid delayed by one cycle
//   spike_count : saturating total of spikes across all channels
// master drives the inputs of the core; slave is the core itself.
// ----------------------------------------------------------------------------
interface lif_array_if #(
   parameter int N = 4,
   parameter int W = 8
);
   logic           in_valid;
   logic [N*W-1:0] current;
   logic           cfg_we;
   logic [1:0]     cfg_sel;
   logic [W-1:0]   cfg_data;
   logic [N*W-1:0] state;
   logic [N-1:0]   spike;
   logic [N-1:0]   refractory;
   logic           spike_valid;
   logic [15:0]    spike_count;

   modport master (
      output in_valid, current, cfg_we, cfg_sel, cfg_data,
      input  state, spike, refractory, spike_valid, spike_count
   );

   modport slave (
      input  in_valid, current, cfg_we, cfg_sel, cfg_data,
      output state, spike, refractory, spike_valid, spike_count
   );
endinterface

// File: rtl/lif_array.sv
// ----------------------------------------------------------------------------
// lif_array
// N leaky integrate-and-fire neurons updated in parallel on every valid beat,
// with saturating integration, programmable threshold / leak / refractory
// period and a saturating aggregate spike counter.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : lif_array_if slave modport (beat input, config port, outputs)
// All outputs come straight from registers; latency from beat to output is
// one clock.
// ----------------------------------------------------------------------------
module lif_array #(
   parameter int N          = 4,
   parameter int W          = 8,
   parameter int REF_W      = 3,
   parameter int THRESH_RST = 15,
   parameter int LEAK_RST   = 1,
   parameter int REF_RST    = 0
) (
   input logic        clk,
   input logic        reset,
   lif_array_if.slave bus
);

   typedef enum logic [1:0] {
      SEL_THRESH = 2'd0,
      SEL_PERIOD = 2'd1,
      SEL_LEAK   = 2'd2,
      SEL_CLEAR  = 2'd3
   } cfg_sel_e;

   // Configuration registers
   logic [W-1:0]     thresh_q;
   logic [2:0]       leak_q;
   logic [REF_W-1:0] period_q;

   // Per-channel neuron state
   logic [W-1:0]     mem_q [N];
   logic [REF_W-1:0] cnt_q [N];
   logic [N-1:0]     spike_q;
   logic             valid_q;
   logic [15:0]      count_q;

   // Next-state values
   logic [W-1:0]     mem_d [N];
   logic [REF_W-1:0] cnt_d [N];
   logic [N-1:0]     spike_d;
   logic [15:0]      n_fire;
   logic [16:0]      count_sum;
   logic [2:0]       leak_wr;
   logic             clear;

   // Leak shifts beyond W-1 would just zero the membrane; clamp them.
   assign leak_wr   = ({29'd0, bus.cfg_data[2:0]} > W - 1) ? 3'(W - 1) : bus.cfg_data[2:0];
   assign clear     = bus.cfg_we && (cfg_sel_e'(bus.cfg_sel) == SEL_CLEAR);
   assign count_sum = {1'b0, count_q} + {1'b0, n_fire};

   // Neuron update, computed from pre-edge state and pre-edge configuration so
   // a write in the same cycle only takes effect on the following beat.
   always_comb begin
      logic [W:0]   sum;
      logic [W-1:0] sat;
      // NOTE: every combinationally written variable gets a default first so
      // no path leaves it unassigned and no latch is inferred.
      spike_d = '0;
      n_fire  = '0;
      for (int i = 0; i < N; i++) begin
         mem_d[i] = mem_q[i];
         cnt_d[i] = cnt_q[i];
         sum      = '0;
         sat      = '0;
         if (bus.in_valid) begin
            if (cnt_q[i] != '0) begin
               // Refractory: input ignored, membrane clamped at rest.
               cnt_d[i] = cnt_q[i] - 1'b1;
               mem_d[i] = '0;
            end else begin
               // One extra bit of headroom catches the carry for saturation.
               sum = {1'b0, bus.current[i*W +: W]} + {1'b0, mem_q[i] >> leak_q};
               sat = sum[W] ? '1 : sum[W-1:0];
               if (sat >= thresh_q) begin
                  spike_d[i] = 1'b1;
                  mem_d[i]   = '0;
                  cnt_d[i]   = period_q;
               end else begin
                  mem_d[i] = sat;
               end
            end
         end
         n_fire = n_fire + 16'(spike_d[i]);
      end
   end

   // NOTE: sequential state is assigned with non-blocking (<=) so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         thresh_q <= W'(THRESH_RST);
         leak_q   <= 3'(LEAK_RST);
         period_q <= REF_W'(REF_RST);
      end else if (bus.cfg_we) begin
         case (cfg_sel_e'(bus.cfg_sel))
            SEL_THRESH: thresh_q <= bus.cfg_data;
            SEL_PERIOD: period_q <= bus.cfg_data[REF_W-1:0];
            SEL_LEAK:   leak_q   <= leak_wr;
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the per-channel arrays are reset element by element because
         // a reset must abandon refractory counts in progress; these are small
         // register arrays, not RAM, so the reset costs nothing special.
         for (int i = 0; i < N; i++) begin
            mem_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         spike_q <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            mem_q[i] <= mem_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         spike_q <= spike_d;
         valid_q <= bus.in_valid;
         // Clear wins over spikes landing in the same cycle.
         if (clear)
            count_q <= '0;
         else if (count_sum[16])
            count_q <= '1;
         else
            count_q <= count_sum[15:0];
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_out
      assign bus.state[g*W +: W] = mem_q[g];
      assign bus.refractory[g]   = |cnt_q[g];
   end

   assign bus.spike       = spike_q;
   assign bus.spike_valid = valid_q;
   assign bus.spike_count = count_q;

endmodule
